// File: rtl/ysyx_24070017_pkg.sv
// Shared opcode constants and instruction-format encoding for the NPC decode stage.
package ysyx_24070017_pkg;

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [6:0] OP_IMM32   = 7'b0011011;
  localparam logic [6:0] OP         = 7'b0110011;
  localparam logic [6:0] OP32       = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OP_MISCMEM = 7'b0001111;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

endpackage

// File: rtl/ysyx_24070017_idu_dec.sv
// Pure combinational RISC-V decoder: fields, format class, sign-extended immediate.
// Optional macro YSYX_24070017_RVE_EN rejects register indices >= 16.
module ysyx_24070017_idu_dec
  import ysyx_24070017_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output fmt_e            fmt,
  output logic [XLEN-1:0] imm,
  output logic            rd_we,
  output logic            illegal
);

  fmt_e               base_fmt;
  logic               rve_bad;
  logic signed [31:0] imm32;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  always_comb begin
    base_fmt = FMT_ILL;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:0])
        OP_LUI, OP_AUIPC:                                   base_fmt = FMT_U;
        OP_JAL:                                             base_fmt = FMT_J;
        OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM, OP_MISCMEM:    base_fmt = FMT_I;
        OP_STORE:                                           base_fmt = FMT_S;
        OP_BRANCH:                                          base_fmt = FMT_B;
        OP:                                                 base_fmt = FMT_R;
        OP32:      if (XLEN == 64)                          base_fmt = FMT_R;
        OP_IMM32:  if (XLEN == 64)                          base_fmt = FMT_I;
        default:                                            base_fmt = FMT_ILL;
      endcase
    end
  end

  always_comb begin
    rve_bad = 1'b0;
`ifdef YSYX_24070017_RVE_EN
    case (base_fmt)
      FMT_R:        rve_bad = rd[4] | rs1[4] | rs2[4];
      FMT_I:        rve_bad = rd[4] | rs1[4];
      FMT_S, FMT_B: rve_bad = rs1[4] | rs2[4];
      FMT_U, FMT_J: rve_bad = rd[4];
      default:      rve_bad = 1'b0;
    endcase
`endif
  end

  assign fmt     = rve_bad ? FMT_ILL : base_fmt;
  assign illegal = (fmt == FMT_ILL);
  assign rd_we   = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J)
                   && (rd != 5'd0) && !illegal;

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm32 = {inst[31:12], 12'b0};
      FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // imm32 is signed, so the cast sign-extends to XLEN for RV64.
  assign imm = XLEN'(imm32);

endmodule

// File: rtl/ysyx_24070017_idu_stage.sv
// Registered decode stage between IFU and EXU with a one-entry skid buffer.
// Optional macro YSYX_24070017_RVE_EN (consumed by the decoder) selects RV32E/RV64E.
module ysyx_24070017_idu_stage
  import ysyx_24070017_pkg::*;
#(
  parameter int unsigned XLEN              = 32,
  parameter int unsigned RESET_PC_DONTCARE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_rd_we,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            rd_we;
    logic            illegal;
  } bundle_t;

  bundle_t in_b, out_q, skid_q;
  fmt_e    dec_fmt;
  logic    skid_valid;
  logic    in_fire, load_out;
  logic    out_valid_d, skid_valid_d;

  ysyx_24070017_idu_dec #(.XLEN(XLEN)) u_dec (
    .inst    (in_inst),
    .opcode  (in_b.opcode),
    .rd      (in_b.rd),
    .rs1     (in_b.rs1),
    .rs2     (in_b.rs2),
    .funct3  (in_b.funct3),
    .funct7  (in_b.funct7),
    .fmt     (dec_fmt),
    .imm     (in_b.imm),
    .rd_we   (in_b.rd_we),
    .illegal (in_b.illegal)
  );

  assign in_b.pc  = in_pc;
  assign in_b.fmt = dec_fmt;

  assign in_fire  = in_valid && in_ready;
  assign load_out = !out_valid || out_ready;

  always_comb begin
    out_valid_d  = out_valid;
    skid_valid_d = skid_valid;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (load_out) begin
      // in_ready is low whenever the skid is full, so only one source can be live.
      out_valid_d  = skid_valid || in_fire;
      skid_valid_d = 1'b0;
    end else begin
      out_valid_d  = 1'b1;
      skid_valid_d = skid_valid || in_fire;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      out_valid  <= out_valid_d;
      skid_valid <= skid_valid_d;
      in_ready   <= !skid_valid_d;
    end
  end

  generate
    if (RESET_PC_DONTCARE != 0) begin : g_data_noreset
      always_ff @(posedge clk) begin
        if (load_out) out_q <= skid_valid ? skid_q : in_b;
        if (!load_out && in_fire) skid_q <= in_b;
      end
    end else begin : g_data_reset
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q  <= '0;
          skid_q <= '0;
        end else begin
          if (load_out) out_q <= skid_valid ? skid_q : in_b;
          if (!load_out && in_fire) skid_q <= in_b;
        end
      end
    end
  endgenerate

  assign out_pc      = out_q.pc;
  assign out_opcode  = out_q.opcode;
  assign out_rd      = out_q.rd;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_funct3  = out_q.funct3;
  assign out_funct7  = out_q.funct7;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_rd_we   = out_q.rd_we;
  assign out_illegal = out_q.illegal;

endmodule
